// File: rtl/i2s_rx_pkg.sv
// Shared definitions for the I2S receiver: channel codes, FSM states and the
// default sample width.
package i2s_rx_pkg;

  localparam int unsigned BITSIZE_DEFAULT = 16;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  // Encodings kept identical to the legacy state codes.
  typedef enum logic [1:0] {
    ST_WAIT_SYNC = 2'd0,
    ST_SHIFT     = 2'd1,
    ST_DONE      = 2'd2
  } state_e;

endpackage

// File: rtl/i2s_rx_sync_edge.sv
// Synchroniser and bclk rise detector for the I2S receiver.
//  clk, reset : system clock, synchronous active-high reset
//  bclk, lrclk, sdata : asynchronous codec pins
//  bclk_rise  : 1-cycle pulse per synchronised bclk 0->1
//  lrclk_s, sdata_s : synchronised lrclk/sdata, aligned with bclk_rise
module i2s_rx_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic bclk,
  input  logic lrclk,
  input  logic sdata,
  output logic bclk_rise,
  output logic lrclk_s,
  output logic sdata_s
);

  logic [SYNC_STAGES-1:0] bclk_sync_q, bclk_sync_d;
  logic [SYNC_STAGES-1:0] lr_sync_q, lr_sync_d;
  logic [SYNC_STAGES-1:0] sd_sync_q, sd_sync_d;
  logic bclk_prev_q, bclk_prev_d;
  logic bclk_rise_q, bclk_rise_d;
  logic lrclk_s_q, lrclk_s_d;
  logic sdata_s_q, sdata_s_d;

  // The rise strobe is registered together with lrclk/sdata so all three
  // stay aligned for the FSM.
  always_comb begin
    bclk_sync_d = {bclk_sync_q[SYNC_STAGES-2:0], bclk};
    lr_sync_d   = {lr_sync_q[SYNC_STAGES-2:0], lrclk};
    sd_sync_d   = {sd_sync_q[SYNC_STAGES-2:0], sdata};
    bclk_prev_d = bclk_sync_q[SYNC_STAGES-1];
    bclk_rise_d = bclk_sync_q[SYNC_STAGES-1] & ~bclk_prev_q;
    lrclk_s_d   = lr_sync_q[SYNC_STAGES-1];
    sdata_s_d   = sd_sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_sync_q <= '0;
      lr_sync_q   <= '0;
      sd_sync_q   <= '0;
      bclk_prev_q <= 1'b0;
      bclk_rise_q <= 1'b0;
      lrclk_s_q   <= 1'b0;
      sdata_s_q   <= 1'b0;
    end else begin
      bclk_sync_q <= bclk_sync_d;
      lr_sync_q   <= lr_sync_d;
      sd_sync_q   <= sd_sync_d;
      bclk_prev_q <= bclk_prev_d;
      bclk_rise_q <= bclk_rise_d;
      lrclk_s_q   <= lrclk_s_d;
      sdata_s_q   <= sdata_s_d;
    end
  end

  assign bclk_rise = bclk_rise_q;
  assign lrclk_s   = lrclk_s_q;
  assign sdata_s   = sdata_s_q;

endmodule

// File: rtl/i2s_rx.sv
// I2S capture receiver: oversamples the codec ADC stream and emits one
// signed left/right pair per frame.
//  clk, reset  : system clock (>= 4x bclk), synchronous active-high reset
//  bclk, lrclk, sdata : codec bit clock, ADCLRC (0 = left), ADCDAT
//  left_out, right_out : captured samples, change only with valid
//  valid       : 1-cycle strobe for a new pair
//  locked      : 1 while aligned to frames
//  frame_err   : 1-cycle strobe when a slot ends before BITSIZE bits
module i2s_rx
  import i2s_rx_pkg::*;
#(
  parameter int unsigned BITSIZE     = BITSIZE_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bclk,
  input  logic                      lrclk,
  input  logic                      sdata,
  output logic signed [BITSIZE-1:0] left_out,
  output logic signed [BITSIZE-1:0] right_out,
  output logic                      valid,
  output logic                      locked,
  output logic                      frame_err
);

  localparam int unsigned CW = $clog2(BITSIZE + 1);

  logic bclk_rise, lrclk_s, sdata_s;

  i2s_rx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .reset     (reset),
    .bclk      (bclk),
    .lrclk     (lrclk),
    .sdata     (sdata),
    .bclk_rise (bclk_rise),
    .lrclk_s   (lrclk_s),
    .sdata_s   (sdata_s)
  );

  state_e               state_q, state_d;
  logic                 chan_q, chan_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BITSIZE-1:0]   shift_q, shift_d;
  logic [BITSIZE-1:0]   hold_q, hold_d;
  logic                 lr_prev_q, lr_prev_d;
  logic [BITSIZE-1:0]   left_q, left_d;
  logic [BITSIZE-1:0]   right_q, right_d;
  logic                 valid_q, valid_d;
  logic                 locked_q, locked_d;
  logic                 frame_err_q, frame_err_d;
  logic [BITSIZE-1:0]   word;
  logic                 lr_change;

  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    lr_prev_d   = lr_prev_q;
    left_d      = left_q;
    right_d     = right_q;
    locked_d    = locked_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
    word        = {shift_q[BITSIZE-2:0], sdata_s};
    lr_change   = (lrclk_s != lr_prev_q);

    // The rise that carries an lrclk change is the I2S delay bit, so it only
    // steers the FSM and never shifts data in.
    if (bclk_rise) begin
      lr_prev_d = lrclk_s;
      unique case (state_q)
        ST_WAIT_SYNC: begin
          if (lr_change && lrclk_s == CH_LEFT) begin
            state_d  = ST_SHIFT;
            chan_d   = CH_LEFT;
            cnt_d    = '0;
            locked_d = 1'b1;
          end
        end
        ST_SHIFT: begin
          if (lr_change) begin
            // Short slot: the consumed edge cannot also resync.
            state_d     = ST_WAIT_SYNC;
            shift_d     = '0;
            frame_err_d = 1'b1;
            locked_d    = 1'b0;
          end else begin
            shift_d = word;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CW'(BITSIZE - 1)) begin
              state_d = ST_DONE;
              if (chan_q == CH_RIGHT) begin
                left_d  = hold_q;
                right_d = word;
                valid_d = 1'b1;
              end else begin
                hold_d = word;
              end
            end
          end
        end
        ST_DONE: begin
          if (lr_change) begin
            state_d = ST_SHIFT;
            chan_d  = lrclk_s;
            cnt_d   = '0;
          end
        end
        default: state_d = ST_WAIT_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_WAIT_SYNC;
      chan_q      <= CH_LEFT;
      cnt_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      lr_prev_q   <= 1'b0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      lr_prev_q   <= lr_prev_d;
      left_q      <= left_d;
      right_q     <= right_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign left_out  = left_q;
  assign right_out = right_q;
  assign valid     = valid_q;
  assign locked    = locked_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: directed frame table, hand-written reset
// corner cases and a randomized slot stream against a slot-level model.
module tb_i2s_rx;

  localparam int unsigned B  = 16;
  localparam int unsigned SS = 2;

  logic clk = 1'b0;
  logic reset, bclk, lrclk, sdata;
  logic [B-1:0] left_out, right_out;
  logic valid, locked, frame_err;

  i2s_rx #(.BITSIZE(B), .SYNC_STAGES(SS)) dut (
    .clk       (clk),
    .reset     (reset),
    .bclk      (bclk),
    .lrclk     (lrclk),
    .sdata     (sdata),
    .left_out  (left_out),
    .right_out (right_out),
    .valid     (valid),
    .locked    (locked),
    .frame_err (frame_err)
  );

  always #10 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned vectors = 0, miscompares = 0;
  int unsigned err_seen = 0, err_locked = 0;
  int unsigned h = 8;
  int unsigned rise_cyc = 0, lsb_cyc = 0;

  typedef struct { logic [B-1:0] l; logic [B-1:0] r; int unsigned cyc; } pair_t;
  typedef struct { logic [B-1:0] l; logic [B-1:0] r; } exp_t;
  pair_t got_q[$];
  exp_t  exp_q[$];
  logic [B-1:0] prev_l = '0, prev_r = '0;

  // Records every valid pulse; checks outputs hold between pulses.
  always @(negedge clk) begin
    if (!reset) begin
      if (valid) got_q.push_back('{left_out, right_out, cyc});
      if (frame_err) begin
        err_seen++;
        if (locked) err_locked++;
      end
      if (!valid) begin
        vectors++;
        if (left_out !== prev_l || right_out !== prev_r) begin
          miscompares++;
          $display("FAIL hold: outputs %h/%h changed without valid, required %h/%h",
                   left_out, right_out, prev_l, prev_r);
        end
      end
    end
    prev_l = left_out;
    prev_r = right_out;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fall(input logic lr, input logic d);
    bclk = 1'b0; lrclk = lr; sdata = d;
    repeat (h) @(negedge clk);
  endtask

  task automatic rise();
    bclk = 1'b1; rise_cyc = cyc;
    repeat (h) @(negedge clk);
  endtask

  // One slot of s bclk periods: delay bit, MSB..LSB, then pad bits.
  task automatic send_slot(input logic c, input int unsigned s, input logic [B-1:0] w,
                           input logic pad);
    logic d;
    for (int unsigned i = 0; i < s; i++) begin
      d = pad;
      if (i >= 1 && i <= B) d = w[B-i];
      fall(c, d);
      rise();
      if (i == B) lsb_cyc = rise_cyc;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; bclk = 1'b0; lrclk = 1'b0; sdata = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_left", left_out, 0);
    chk("rst_right", right_out, 0);
    chk("rst_valid", valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_frame_err", frame_err, 0);
    reset = 1'b0;
    got_q.delete();
    err_seen = 0; err_locked = 0;
  endtask

  // Slot-level reference: a frame starts on a left change, a slot with fewer
  // than B data rises is an error once the next change arrives, and that
  // change is consumed.
  logic m_prev, m_sync, m_short;
  logic [B-1:0] m_hold;
  int unsigned m_err;

  task automatic model_slot(input logic c, input int unsigned s, input logic [B-1:0] w);
    if (c != m_prev) begin
      if (m_sync && m_short) begin
        m_err++;
        m_sync = 1'b0;
      end else if (!m_sync && c == 1'b0) begin
        m_sync = 1'b1;
      end
      m_short = (s - 1 < B);
      if (m_sync && !m_short) begin
        if (c == 1'b0) m_hold = w;
        else exp_q.push_back('{m_hold, w});
      end
    end
    m_prev = c;
  endtask

  typedef struct {
    logic [B-1:0] l, r;
    int unsigned  ls, rs;
    logic         pad;
    int unsigned  exp_n;
    logic [B-1:0] exp_l, exp_r;
    int unsigned  exp_err;
    logic         exp_lock;
  } vec_t;

  vec_t vt[8];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [B-1:0] w;
    logic c;
    int unsigned s, n;

    vt[0] = '{16'h1234, 16'hABCD, 32, 32, 1'b0, 1, 16'h1234, 16'hABCD, 0, 1'b1};
    vt[1] = '{16'h0F0E, 16'h5550, 33, 33, 1'b1, 1, 16'h0F0E, 16'h5550, 0, 1'b1};
    vt[2] = '{16'hFFFF, 16'h0001, 10, 32, 1'b0, 0, 16'h0000, 16'h0000, 1, 1'b0};
    vt[3] = '{16'h8000, 16'h7FFF, 32, 32, 1'b0, 1, 16'h8000, 16'h7FFF, 0, 1'b1};
    vt[4] = '{16'hC3A5, 16'h0000, 16, 32, 1'b1, 0, 16'h0000, 16'h0000, 1, 1'b0};
    vt[5] = '{16'hA5A5, 16'h5A5A, 17, 17, 1'b0, 1, 16'hA5A5, 16'h5A5A, 0, 1'b1};
    vt[6] = '{16'h0001, 16'hFFFE, 64, 64, 1'b1, 1, 16'h0001, 16'hFFFE, 0, 1'b1};
    vt[7] = '{16'h7FFF, 16'h8000, 32, 32, 1'b0, 1, 16'h7FFF, 16'h8000, 0, 1'b1};

    reset = 1'b1; bclk = 1'b0; lrclk = 1'b0; sdata = 1'b0;
    @(negedge clk);

    // Directed table at clk/bclk = 16.
    h = 8;
    do_reset();
    send_slot(1'b0, 32, 16'h0000, 1'b0);
    send_slot(1'b1, 32, 16'h0000, 1'b0);
    chk("sync_frame_valid", got_q.size(), 0);
    chk("sync_frame_locked", locked, 0);
    for (int unsigned k = 0; k < 8; k++) begin
      got_q.delete(); err_seen = 0; err_locked = 0;
      send_slot(1'b0, vt[k].ls, vt[k].l, vt[k].pad);
      send_slot(1'b1, vt[k].rs, vt[k].r, vt[k].pad);
      repeat (8) @(negedge clk);
      chk($sformatf("vec%0d_nvalid", k), got_q.size(), vt[k].exp_n);
      if (got_q.size() > 0 && vt[k].exp_n > 0) begin
        chk($sformatf("vec%0d_left", k), got_q[0].l, vt[k].exp_l);
        chk($sformatf("vec%0d_right", k), got_q[0].r, vt[k].exp_r);
        chk($sformatf("vec%0d_latency", k), got_q[0].cyc - lsb_cyc, SS + 2);
      end
      chk($sformatf("vec%0d_frame_err", k), err_seen, vt[k].exp_err);
      chk($sformatf("vec%0d_err_locked", k), err_locked, 0);
      chk($sformatf("vec%0d_locked", k), locked, vt[k].exp_lock);
    end

    // clk/bclk = 4, eight back-to-back counting frames.
    h = 2;
    got_q.delete();
    for (int unsigned k = 0; k < 8; k++) begin
      send_slot(1'b0, 32, 16'(2 * k), 1'b0);
      send_slot(1'b1, 32, 16'(2 * k + 1), 1'b0);
    end
    repeat (8) @(negedge clk);
    chk("count_nvalid", got_q.size(), 8);
    for (int unsigned k = 0; k < 8 && k < got_q.size(); k++) begin
      chk($sformatf("count%0d_left", k), got_q[k].l, 16'(2 * k));
      chk($sformatf("count%0d_right", k), got_q[k].r, 16'(2 * k + 1));
    end

    // Reset released in the middle of a right slot.
    h = 4;
    do_reset();
    send_slot(1'b1, 32, 16'h0000, 1'b0);
    send_slot(1'b0, 32, 16'h1357, 1'b0);
    send_slot(1'b1, 9, 16'h2468, 1'b0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    got_q.delete(); err_seen = 0;
    w = 16'h2468;
    for (int unsigned i = 9; i < 32; i++) begin
      fall(1'b1, (i <= B) ? w[B-i] : 1'b0);
      rise();
    end
    chk("midrst_locked", locked, 0);
    chk("midrst_nvalid", got_q.size(), 0);
    send_slot(1'b0, 32, 16'hCAFE, 1'b0);
    send_slot(1'b1, 32, 16'hBEEF, 1'b0);
    repeat (8) @(negedge clk);
    chk("midrst_after_nvalid", got_q.size(), 1);
    if (got_q.size() > 0) begin
      chk("midrst_after_left", got_q[0].l, 16'hCAFE);
      chk("midrst_after_right", got_q[0].r, 16'hBEEF);
    end
    chk("midrst_frame_err", err_seen, 0);

    // Reset lands on the edge where valid would rise.
    do_reset();
    send_slot(1'b1, 32, 16'h0000, 1'b0);
    send_slot(1'b0, 32, 16'h1111, 1'b0);
    w = 16'h2222;
    send_slot(1'b1, B, w, 1'b0);
    fall(1'b1, w[0]);
    bclk = 1'b1;
    repeat (SS + 1) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rstvalid_valid_in_reset", valid, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rstvalid_nvalid", got_q.size(), 0);
    chk("rstvalid_left", left_out, 0);
    chk("rstvalid_right", right_out, 0);
    chk("rstvalid_valid", valid, 0);

    // Randomized slot stream, mixing full and short slots.
    h = 2;
    do_reset();
    m_prev = 1'b0; m_sync = 1'b0; m_short = 1'b0; m_hold = '0; m_err = 0;
    exp_q.delete();
    c = 1'($urandom_range(0, 1));
    for (int unsigned k = 0; k < 40; k++) begin
      if ($urandom_range(0, 5) == 0) s = $urandom_range(2, B);
      else s = $urandom_range(B + 1, 34);
      w = 16'($urandom);
      model_slot(c, s, w);
      send_slot(c, s, w, 1'($urandom_range(0, 1)));
      c = ~c;
    end
    repeat (12) @(negedge clk);
    chk("rand_nvalid", got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int unsigned k = 0; k < n; k++) begin
      chk($sformatf("rand%0d_left", k), got_q[k].l, exp_q[k].l);
      chk($sformatf("rand%0d_right", k), got_q[k].r, exp_q[k].r);
    end
    chk("rand_frame_err", err_seen, m_err);
    chk("rand_err_locked", err_locked, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
